// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding MEM-stage word memory with programmable wait states and error flagging
module dmem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t        state, state_d;
    logic [3:0]    cnt;
    logic          we_q;
    logic [31:0]   addr_q, wdata_q;
    logic [3:0]    be_q;
    logic [32:0]   off;
    logic          err, access;
    logic [31:0]   mem [DEPTH_WORDS];
    assign off    = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    assign err    = |addr_q[1:0] || off[32] || off[31:0] >= 32'(4 * DEPTH_WORDS);
    assign access = state == WAIT && cnt == 4'd0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end
    always_comb begin
        state_d = state == IDLE ? (req_valid ? WAIT : IDLE)
                : state == WAIT ? (cnt == 4'd0 ? RESP : WAIT)
                : (rsp_ready ? IDLE : RESP);
    end
    always_comb begin
        req_ready = state == IDLE;
        rsp_valid = state == RESP;
        busy      = state != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                cnt     <= 4'(WAIT_CYCLES);
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                rsp_rdata <= (err || we_q) ? 32'd0 : mem[off[AW+1:2]];
                rsp_err   <= err;
            end else if (state == RESP && rsp_ready) begin
                rsp_rdata <= 32'd0;
                rsp_err   <= 1'b0;
            end
        end
    end
    // storage is deliberately unreset; an aborted access never reaches this edge because state is forced to IDLE
    always_ff @(posedge clk) begin
        if (access && we_q && !err)
            for (int i = 0; i < 4; i++)
                if (be_q[i]) mem[off[AW+1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for two responders (WAIT_CYCLES 2 and 0)
module tb_dmem_responder;
    logic        clk = 1'b1;
    logic        rst_n     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        busy      [2];
    logic [32:0] exp_q [2][$];
    int          n_chk = 0;
    int          n_pass = 0;
    always #5 clk = ~clk;
    dmem_responder #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0])
    );
    dmem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1])
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    for (genvar g = 0; g < 2; g++) begin : mon
        always begin
            @(negedge clk);
            #1;
            if (rsp_valid[g] && rsp_ready[g]) begin
                if (exp_q[g].size() == 0) begin
                    chk($sformatf("unexpected_rsp%0d", g), 32'd1, 32'd0);
                end else begin
                    logic [32:0] e;
                    e = exp_q[g].pop_front();
                    chk($sformatf("rdata%0d", g), rsp_rdata[g], e[31:0]);
                    chk($sformatf("err%0d", g), {31'd0, rsp_err[g]}, {31'd0, e[32]});
                end
            end
        end
    end
    task automatic drive(input int s, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid[s] = 1'b1;
        req_we[s]    = we;
        req_addr[s]  = addr;
        req_wdata[s] = wd;
        req_be[s]    = be;
        @(posedge clk);
        @(negedge clk);
        req_valid[s] = 1'b0;
    endtask
    task automatic do_req(input int s, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] exp_d, input logic exp_e,
                          input int lat, input bit hs);
        int n;
        exp_q[s].push_back({exp_e, exp_d});
        drive(s, we, addr, wd, be);
        n = 0;
        while (!rsp_valid[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("latency%0d_%h", s, addr), n, lat);
        if (hs) begin
            n = 0;
            while (rsp_valid[s] && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
    endtask
    task automatic check_reset(input int s);
        chk($sformatf("rst_req_ready%0d", s), {31'd0, req_ready[s]}, 32'd1);
        chk($sformatf("rst_rsp_valid%0d", s), {31'd0, rsp_valid[s]}, 32'd0);
        chk($sformatf("rst_busy%0d", s), {31'd0, busy[s]}, 32'd0);
        chk($sformatf("rst_rdata%0d", s), rsp_rdata[s], 32'd0);
        chk($sformatf("rst_err%0d", s), {31'd0, rsp_err[s]}, 32'd0);
    endtask
    task automatic abort_store(input int s, input logic [31:0] addr, input logic [31:0] wd, input int d);
        drive(s, 1'b1, addr, wd, 4'hF);
        repeat (d - 1) @(negedge clk);
        rst_n[s] = 1'b0;
        #1;
        check_reset(s);
        @(negedge clk);
        rst_n[s] = 1'b1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
    initial begin
        int seen;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
            req_wdata[i] = '0; req_be[i] = '0; rsp_ready[i] = 1'b1;
        end
        #15;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        #1;
        check_reset(0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid[0]) seen++;
        end
        chk("idle_no_rsp", seen, 0);
        do_req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 3, 1);
        do_req(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 3, 1);
        do_req(0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0, 0, 3, 1);
        do_req(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 0, 3, 1);
        do_req(0, 0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 0, 3, 1);
        do_req(0, 1, 32'h10, 32'h55555555, 4'h0, 32'h0, 0, 3, 1);
        do_req(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 3, 1);
        do_req(0, 0, 32'h22, 32'h0, 4'h0, 32'h0, 1, 3, 1);
        do_req(0, 1, 32'h3FC, 32'h0BADF00D, 4'hF, 32'h0, 0, 3, 1);
        do_req(0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1, 3, 1);
        do_req(0, 0, 32'h3FC, 32'h0, 4'h0, 32'h0BADF00D, 0, 3, 1);
        rsp_ready[0] = 1'b0;
        do_req(0, 0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 0, 3, 0);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h10; req_wdata[0] = 32'h0; req_be[0] = 4'hF;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, rsp_valid[0]}, 32'd1);
            chk("bp_rdata", rsp_rdata[0], 32'h11BB33DD);
            chk("bp_err", {31'd0, rsp_err[0]}, 32'd0);
            chk("bp_req_ready", {31'd0, req_ready[0]}, 32'd0);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {31'd0, rsp_valid[0]}, 32'd0);
        chk("bp_release_ready", {31'd0, req_ready[0]}, 32'd1);
        do_req(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 3, 1);
        do_req(0, 1, 32'h30, 32'hCAFEF00D, 4'hF, 32'h0, 0, 3, 1);
        abort_store(0, 32'h30, 32'h12345678, 2);
        do_req(0, 0, 32'h30, 32'h0, 4'h0, 32'hCAFEF00D, 0, 3, 1);
        do_req(1, 1, 32'h30, 32'hCAFEF00D, 4'hF, 32'h0, 0, 1, 1);
        abort_store(1, 32'h30, 32'h12345678, 1);
        do_req(1, 0, 32'h30, 32'h0, 4'h0, 32'hCAFEF00D, 0, 1, 1);
        do_req(1, 1, 32'h34, 32'h12345678, 4'hF, 32'h0, 0, 1, 1);
        do_req(1, 0, 32'h34, 32'h0, 4'h0, 32'h12345678, 0, 1, 1);
        repeat (5) @(negedge clk);
        chk("queue0_empty", exp_q[0].size(), 0);
        chk("queue1_empty", exp_q[1].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
